// File: rtl/cache_axi_pkg.sv
// Shared constants and types for the data-cache AXI bridge.
// Covers the AXI field encodings, the read/write FSM states and the request kind.
package cache_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [7:0] LINE_LEN       = 8'd3;
  localparam logic [7:0] SINGLE_LEN     = 8'd0;

  typedef enum logic [1:0] {
    R_IDLE,
    R_AR,
    R_DATA,
    R_RET
  } ReadState;

  typedef enum logic [2:0] {
    W_IDLE,
    W_AW,
    W_DATA,
    W_RESP,
    W_DONE
  } WriteState;

  typedef enum logic {
    LINE,
    UNCACHED
  } ReqType;

  // AXI beat count minus one for a request kind
  function automatic logic [7:0] burstLen(input ReqType kind);
    return (kind == LINE) ? LINE_LEN : SINGLE_LEN;
  endfunction

endpackage

// File: rtl/dcache_axi_bridge_if.sv
// AXI4 master-side channel bundle (AR/R/AW/W/B) used between the bridge and the interconnect.
interface dcache_axi_bridge_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

endinterface

// File: rtl/axi_line_buffer.sv
// Four-word line register: beat-indexed write and read plus a full 128-bit load and view.
// Word i occupies bits [32i+31:32i] of the line view.
module axi_line_buffer (
  input  logic         clk,
  input  logic         reset,
  input  logic         beatWrEn_i,
  input  logic [1:0]   beatWrIdx_i,
  input  logic [31:0]  beatWrData_i,
  input  logic         lineLoadEn_i,
  input  logic [127:0] lineLoadData_i,
  input  logic [1:0]   beatRdIdx_i,
  output logic [31:0]  beatRdData_o,
  output logic [127:0] line_o
);

  logic [31:0] word_q [4];
  logic [31:0] word_d [4];

  // A full-line load takes priority over a single-beat write
  always_comb begin
    word_d = word_q;
    if (lineLoadEn_i) begin
      for (int i = 0; i < 4; i++) begin
        word_d[i] = lineLoadData_i[32*i +: 32];
      end
    end else if (beatWrEn_i) begin
      word_d[beatWrIdx_i] = beatWrData_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        word_q[i] <= '0;
      end
    end else begin
      word_q <= word_d;
    end
  end

  assign beatRdData_o = word_q[beatRdIdx_i];
  assign line_o       = {word_q[3], word_q[2], word_q[1], word_q[0]};

endmodule

// File: rtl/dcache_axi_bridge.sv
// Turns DCache line refill/writeback and uncached load/store requests into single AXI
// transactions; independent read and write FSMs, each with one transaction in flight.
module dcache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd1
) (
  input  logic                 clk,
  input  logic                 reset,

  input  logic                 dcache_rd_req_i,
  input  logic [31:0]          dcache_rd_addr_i,
  output logic                 dcache_rd_rdy_o,
  output logic                 dcache_ret_valid_o,
  output logic [127:0]         dcache_ret_data_o,

  input  logic                 dcache_wr_req_i,
  input  logic [31:0]          dcache_wr_addr_i,
  input  logic [127:0]         dcache_wr_data_i,
  output logic                 dcache_wr_rdy_o,
  output logic                 dcache_wr_valid_o,

  input  logic                 udcache_rd_req_i,
  input  logic [31:0]          udcache_rd_addr_i,
  output logic                 udcache_rd_rdy_o,
  output logic                 udcache_ret_valid_o,
  output logic [31:0]          udcache_ret_data_o,

  input  logic                 udcache_wr_req_i,
  input  logic [31:0]          udcache_wr_addr_i,
  input  logic [31:0]          udcache_wr_data_i,
  input  logic [3:0]           udcache_wr_strb_i,
  output logic                 udcache_wr_rdy_o,
  output logic                 udcache_wr_valid_o,

  dcache_axi_bridge_if.master  axi
);

  ReadState     rdState_q, rdState_d;
  ReqType       rdType_q, rdType_d;
  logic [31:0]  rdAddr_q, rdAddr_d;
  logic [7:0]   rdLen_q, rdLen_d;
  logic [1:0]   rdCnt_q, rdCnt_d;
  logic         rdBeatWr;
  logic [127:0] rdLine;
  logic [31:0]  unusedRdBeat;

  WriteState    wrState_q, wrState_d;
  ReqType       wrType_q, wrType_d;
  logic [31:0]  wrAddr_q, wrAddr_d;
  logic [7:0]   wrLen_q, wrLen_d;
  logic [3:0]   wrStrb_q, wrStrb_d;
  logic [1:0]   wrCnt_q, wrCnt_d;
  logic         wrLoad;
  logic [127:0] wrLoadData;
  logic [31:0]  wrBeat;
  logic [127:0] unusedWrLine;

  // Response IDs and status codes carry nothing the cache acts on
  logic unusedAxiFields;
  assign unusedAxiFields = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

  always_ff @(posedge clk) begin
    if (reset) begin
      rdState_q <= R_IDLE;
      rdType_q  <= LINE;
      rdAddr_q  <= '0;
      rdLen_q   <= '0;
      rdCnt_q   <= '0;
    end else begin
      rdState_q <= rdState_d;
      rdType_q  <= rdType_d;
      rdAddr_q  <= rdAddr_d;
      rdLen_q   <= rdLen_d;
      rdCnt_q   <= rdCnt_d;
    end
  end

  always_comb begin
    rdState_d           = rdState_q;
    rdType_d            = rdType_q;
    rdAddr_d            = rdAddr_q;
    rdLen_d             = rdLen_q;
    rdCnt_d             = rdCnt_q;
    rdBeatWr            = 1'b0;
    dcache_rd_rdy_o     = 1'b0;
    udcache_rd_rdy_o    = 1'b0;
    dcache_ret_valid_o  = 1'b0;
    udcache_ret_valid_o = 1'b0;
    axi.arvalid         = 1'b0;
    axi.rready          = 1'b0;
    case (rdState_q)
      R_IDLE: begin
        if (dcache_rd_req_i) begin
          dcache_rd_rdy_o = 1'b1;
          rdType_d        = LINE;
          rdAddr_d        = dcache_rd_addr_i;
          rdLen_d         = burstLen(LINE);
          rdCnt_d         = '0;
          rdState_d       = R_AR;
        end else if (udcache_rd_req_i) begin
          udcache_rd_rdy_o = 1'b1;
          rdType_d         = UNCACHED;
          rdAddr_d         = udcache_rd_addr_i;
          rdLen_d          = burstLen(UNCACHED);
          rdCnt_d          = '0;
          rdState_d        = R_AR;
        end
      end
      R_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) begin
          rdState_d = R_DATA;
        end
      end
      R_DATA: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          rdBeatWr = 1'b1;
          rdCnt_d  = rdCnt_q + 2'd1;
          if (axi.rlast) begin
            rdState_d = R_RET;
          end
        end
      end
      R_RET: begin
        dcache_ret_valid_o  = (rdType_q == LINE);
        udcache_ret_valid_o = (rdType_q == UNCACHED);
        rdState_d           = R_IDLE;
      end
      default: rdState_d = R_IDLE;
    endcase
  end

  axi_line_buffer rdBuf (
    .clk            (clk),
    .reset          (reset),
    .beatWrEn_i     (rdBeatWr),
    .beatWrIdx_i    (rdCnt_q),
    .beatWrData_i   (axi.rdata),
    .lineLoadEn_i   (1'b0),
    .lineLoadData_i ('0),
    .beatRdIdx_i    (2'd0),
    .beatRdData_o   (unusedRdBeat),
    .line_o         (rdLine)
  );

  assign axi.arid           = AXI_ID;
  assign axi.araddr         = rdAddr_q;
  assign axi.arlen          = rdLen_q;
  assign axi.arsize         = AXI_SIZE_4B;
  assign axi.arburst        = AXI_BURST_INCR;
  assign dcache_ret_data_o  = rdLine;
  assign udcache_ret_data_o = rdLine[31:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      wrState_q <= W_IDLE;
      wrType_q  <= LINE;
      wrAddr_q  <= '0;
      wrLen_q   <= '0;
      wrStrb_q  <= '0;
      wrCnt_q   <= '0;
    end else begin
      wrState_q <= wrState_d;
      wrType_q  <= wrType_d;
      wrAddr_q  <= wrAddr_d;
      wrLen_q   <= wrLen_d;
      wrStrb_q  <= wrStrb_d;
      wrCnt_q   <= wrCnt_d;
    end
  end

  // Uncached stores travel through word 0 of the same buffer as line writebacks
  always_comb begin
    wrState_d          = wrState_q;
    wrType_d           = wrType_q;
    wrAddr_d           = wrAddr_q;
    wrLen_d            = wrLen_q;
    wrStrb_d           = wrStrb_q;
    wrCnt_d            = wrCnt_q;
    wrLoad             = 1'b0;
    wrLoadData         = '0;
    dcache_wr_rdy_o    = 1'b0;
    udcache_wr_rdy_o   = 1'b0;
    dcache_wr_valid_o  = 1'b0;
    udcache_wr_valid_o = 1'b0;
    axi.awvalid        = 1'b0;
    axi.wvalid         = 1'b0;
    axi.wlast          = 1'b0;
    axi.bready         = 1'b0;
    case (wrState_q)
      W_IDLE: begin
        if (dcache_wr_req_i) begin
          dcache_wr_rdy_o = 1'b1;
          wrType_d        = LINE;
          wrAddr_d        = dcache_wr_addr_i;
          wrLen_d         = burstLen(LINE);
          wrStrb_d        = 4'hF;
          wrCnt_d         = '0;
          wrLoad          = 1'b1;
          wrLoadData      = dcache_wr_data_i;
          wrState_d       = W_AW;
        end else if (udcache_wr_req_i) begin
          udcache_wr_rdy_o = 1'b1;
          wrType_d         = UNCACHED;
          wrAddr_d         = udcache_wr_addr_i;
          wrLen_d          = burstLen(UNCACHED);
          wrStrb_d         = udcache_wr_strb_i;
          wrCnt_d          = '0;
          wrLoad           = 1'b1;
          wrLoadData       = {96'd0, udcache_wr_data_i};
          wrState_d        = W_AW;
        end
      end
      W_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) begin
          wrState_d = W_DATA;
        end
      end
      W_DATA: begin
        axi.wvalid = 1'b1;
        axi.wlast  = ({6'd0, wrCnt_q} == wrLen_q);
        if (axi.wready) begin
          wrCnt_d = wrCnt_q + 2'd1;
          if ({6'd0, wrCnt_q} == wrLen_q) begin
            wrState_d = W_RESP;
          end
        end
      end
      W_RESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          wrState_d = W_DONE;
        end
      end
      W_DONE: begin
        dcache_wr_valid_o  = (wrType_q == LINE);
        udcache_wr_valid_o = (wrType_q == UNCACHED);
        wrState_d          = W_IDLE;
      end
      default: wrState_d = W_IDLE;
    endcase
  end

  axi_line_buffer wrBuf (
    .clk            (clk),
    .reset          (reset),
    .beatWrEn_i     (1'b0),
    .beatWrIdx_i    (2'd0),
    .beatWrData_i   ('0),
    .lineLoadEn_i   (wrLoad),
    .lineLoadData_i (wrLoadData),
    .beatRdIdx_i    (wrCnt_q),
    .beatRdData_o   (wrBeat),
    .line_o         (unusedWrLine)
  );

  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = wrAddr_q;
  assign axi.awlen   = wrLen_q;
  assign axi.awsize  = AXI_SIZE_4B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wdata   = wrBeat;
  assign axi.wstrb   = wrStrb_q;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Directed bench for dcache_axi_bridge: the bench plays the AXI slave cycle by cycle
// and compares every cache-side and AXI-side output against hand-computed values.
module tb_dcache_axi_bridge;

  logic         clk;
  logic         reset;
  logic         dcache_rd_req, dcache_rd_rdy, dcache_ret_valid;
  logic [31:0]  dcache_rd_addr;
  logic [127:0] dcache_ret_data;
  logic         dcache_wr_req, dcache_wr_rdy, dcache_wr_valid;
  logic [31:0]  dcache_wr_addr;
  logic [127:0] dcache_wr_data;
  logic         udcache_rd_req, udcache_rd_rdy, udcache_ret_valid;
  logic [31:0]  udcache_rd_addr, udcache_ret_data;
  logic         udcache_wr_req, udcache_wr_rdy, udcache_wr_valid;
  logic [31:0]  udcache_wr_addr, udcache_wr_data;
  logic [3:0]   udcache_wr_strb;

  int checkCount;
  int errorCount;

  dcache_axi_bridge_if axi ();

  dcache_axi_bridge #(.AXI_ID(4'd1)) dut (
    .clk                 (clk),
    .reset               (reset),
    .dcache_rd_req_i     (dcache_rd_req),
    .dcache_rd_addr_i    (dcache_rd_addr),
    .dcache_rd_rdy_o     (dcache_rd_rdy),
    .dcache_ret_valid_o  (dcache_ret_valid),
    .dcache_ret_data_o   (dcache_ret_data),
    .dcache_wr_req_i     (dcache_wr_req),
    .dcache_wr_addr_i    (dcache_wr_addr),
    .dcache_wr_data_i    (dcache_wr_data),
    .dcache_wr_rdy_o     (dcache_wr_rdy),
    .dcache_wr_valid_o   (dcache_wr_valid),
    .udcache_rd_req_i    (udcache_rd_req),
    .udcache_rd_addr_i   (udcache_rd_addr),
    .udcache_rd_rdy_o    (udcache_rd_rdy),
    .udcache_ret_valid_o (udcache_ret_valid),
    .udcache_ret_data_o  (udcache_ret_data),
    .udcache_wr_req_i    (udcache_wr_req),
    .udcache_wr_addr_i   (udcache_wr_addr),
    .udcache_wr_data_i   (udcache_wr_data),
    .udcache_wr_strb_i   (udcache_wr_strb),
    .udcache_wr_rdy_o    (udcache_wr_rdy),
    .udcache_wr_valid_o  (udcache_wr_valid),
    .axi                 (axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic readRequest(input bit isLine, input logic [31:0] addr, input string tag);
    @(negedge clk);
    if (isLine) begin
      dcache_rd_req  = 1'b1;
      dcache_rd_addr = addr;
    end else begin
      udcache_rd_req  = 1'b1;
      udcache_rd_addr = addr;
    end
    #1;
    checkOutput({tag, " rd_rdy"}, isLine ? dcache_rd_rdy : udcache_rd_rdy, 1);
  endtask

  // Starts in the accept cycle; drops only this kind's request so another may stay queued
  task automatic readBody(input bit isLine, input logic [31:0] addr, input logic [127:0] data,
                          input int stalls, input string tag);
    int beats;
    beats = isLine ? 4 : 1;
    @(negedge clk);
    if (isLine) dcache_rd_req = 1'b0;
    else        udcache_rd_req = 1'b0;
    axi.arready = 1'b1;
    #1;
    checkOutput({tag, " arvalid"}, axi.arvalid, 1);
    checkOutput({tag, " araddr"}, axi.araddr, addr);
    checkOutput({tag, " arlen"}, axi.arlen, isLine ? 3 : 0);
    checkOutput({tag, " arsize"}, axi.arsize, 3'b010);
    checkOutput({tag, " arburst"}, axi.arburst, 2'b01);
    checkOutput({tag, " arid"}, axi.arid, 4'd1);
    checkOutput({tag, " busy urd_rdy"}, udcache_rd_rdy, 0);
    @(negedge clk);
    axi.arready = 1'b0;
    #1;
    checkOutput({tag, " rready"}, axi.rready, 1);
    checkOutput({tag, " arvalid drop"}, axi.arvalid, 0);
    repeat (stalls) @(negedge clk);
    for (int b = 0; b < beats; b++) begin
      axi.rvalid = 1'b1;
      axi.rdata  = data[32*b +: 32];
      axi.rlast  = (b == beats - 1);
      @(negedge clk);
    end
    axi.rvalid = 1'b0;
    axi.rlast  = 1'b0;
    #1;
    checkOutput({tag, " ret_valid"}, isLine ? dcache_ret_valid : udcache_ret_valid, 1);
    checkOutput({tag, " other ret_valid"}, isLine ? udcache_ret_valid : dcache_ret_valid, 0);
    if (isLine) checkOutput({tag, " ret_data"}, dcache_ret_data, data);
    else        checkOutput({tag, " ret_data"}, udcache_ret_data, data[31:0]);
    @(negedge clk);
    #1;
    checkOutput({tag, " ret_valid end"}, isLine ? dcache_ret_valid : udcache_ret_valid, 0);
    if (isLine) checkOutput({tag, " ret_data hold"}, dcache_ret_data, data);
    else        checkOutput({tag, " ret_data hold"}, udcache_ret_data, data[31:0]);
  endtask

  task automatic writeTxn(input bit isLine, input logic [31:0] addr, input logic [127:0] data,
                          input logic [3:0] strb, input int awDelay, input string tag);
    int beats;
    beats = isLine ? 4 : 1;
    @(negedge clk);
    if (isLine) begin
      dcache_wr_req  = 1'b1;
      dcache_wr_addr = addr;
      dcache_wr_data = data;
    end else begin
      udcache_wr_req  = 1'b1;
      udcache_wr_addr = addr;
      udcache_wr_data = data[31:0];
      udcache_wr_strb = strb;
    end
    #1;
    checkOutput({tag, " wr_rdy"}, isLine ? dcache_wr_rdy : udcache_wr_rdy, 1);
    checkOutput({tag, " other wr_rdy"}, isLine ? udcache_wr_rdy : dcache_wr_rdy, 0);
    @(negedge clk);
    dcache_wr_req  = 1'b0;
    udcache_wr_req = 1'b0;
    #1;
    checkOutput({tag, " awvalid"}, axi.awvalid, 1);
    checkOutput({tag, " awaddr"}, axi.awaddr, addr);
    checkOutput({tag, " awlen"}, axi.awlen, isLine ? 3 : 0);
    checkOutput({tag, " awsize"}, axi.awsize, 3'b010);
    checkOutput({tag, " awburst"}, axi.awburst, 2'b01);
    checkOutput({tag, " awid"}, axi.awid, 4'd1);
    checkOutput({tag, " wvalid early"}, axi.wvalid, 0);
    for (int d = 0; d < awDelay; d++) begin
      @(negedge clk);
      #1;
      checkOutput({tag, " awvalid held"}, axi.awvalid, 1);
    end
    axi.awready = 1'b1;
    @(negedge clk);
    axi.awready = 1'b0;
    for (int b = 0; b < beats; b++) begin
      #1;
      checkOutput({tag, " wvalid"}, axi.wvalid, 1);
      checkOutput({tag, " wdata"}, axi.wdata, data[32*b +: 32]);
      checkOutput({tag, " wstrb"}, axi.wstrb, isLine ? 4'hF : strb);
      checkOutput({tag, " wlast"}, axi.wlast, (b == beats - 1));
      axi.wready = 1'b1;
      @(negedge clk);
      axi.wready = 1'b0;
    end
    #1;
    checkOutput({tag, " bready"}, axi.bready, 1);
    checkOutput({tag, " wvalid end"}, axi.wvalid, 0);
    axi.bvalid = 1'b1;
    @(negedge clk);
    axi.bvalid = 1'b0;
    #1;
    checkOutput({tag, " wr_valid"}, isLine ? dcache_wr_valid : udcache_wr_valid, 1);
    checkOutput({tag, " other wr_valid"}, isLine ? udcache_wr_valid : dcache_wr_valid, 0);
    @(negedge clk);
    #1;
    checkOutput({tag, " wr_valid end"}, isLine ? dcache_wr_valid : udcache_wr_valid, 0);
  endtask

  task automatic applyStimulus();
    // Reset values
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset arvalid", axi.arvalid, 0);
    checkOutput("reset rready", axi.rready, 0);
    checkOutput("reset awvalid", axi.awvalid, 0);
    checkOutput("reset wvalid", axi.wvalid, 0);
    checkOutput("reset bready", axi.bready, 0);
    checkOutput("reset araddr", axi.araddr, 0);
    checkOutput("reset awaddr", axi.awaddr, 0);
    checkOutput("reset wdata", axi.wdata, 0);
    checkOutput("reset ret_data", dcache_ret_data, 0);
    checkOutput("reset uret_data", udcache_ret_data, 0);
    checkOutput("reset pulses", {dcache_rd_rdy, dcache_ret_valid, dcache_wr_rdy, dcache_wr_valid,
                udcache_rd_rdy, udcache_ret_valid, udcache_wr_rdy, udcache_wr_valid}, 0);
    @(negedge clk);
    reset = 1'b0;

    readRequest(1'b1, 32'h1FC0_0040, "refill");
    readBody(1'b1, 32'h1FC0_0040, 128'h00000044_00000033_00000022_00000011, 0, "refill");

    readRequest(1'b0, 32'hBFAF_8000, "uload");
    readBody(1'b0, 32'hBFAF_8000, {96'd0, 32'hDEADBEEF}, 2, "uload");

    writeTxn(1'b1, 32'h0000_2A80, 128'hAFAEADAC_ABAAA9A8_A7A6A5A4_A3A2A1A0, 4'hF, 3, "wback");
    writeTxn(1'b0, 32'hBFD0_0010, {96'd0, 32'h0000AB00}, 4'b0010, 0, "ustore");

    // Both reads requested together: the line wins, the uncached one waits its turn
    @(negedge clk);
    dcache_rd_req   = 1'b1;
    dcache_rd_addr  = 32'h0000_1000;
    udcache_rd_req  = 1'b1;
    udcache_rd_addr = 32'hBFAF_0004;
    #1;
    checkOutput("both rd_rdy", dcache_rd_rdy, 1);
    checkOutput("both urd_rdy", udcache_rd_rdy, 0);
    readBody(1'b1, 32'h0000_1000, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, 0, "both line");
    checkOutput("both urd_rdy after ret", udcache_rd_rdy, 1);
    readBody(1'b0, 32'hBFAF_0004, {96'd0, 32'h12345678}, 0, "both unc");

    // Reset lands while beat 2 of a refill is on the bus
    readRequest(1'b1, 32'h0000_3000, "abort");
    @(negedge clk);
    dcache_rd_req = 1'b0;
    axi.arready   = 1'b1;
    @(negedge clk);
    axi.arready = 1'b0;
    axi.rvalid  = 1'b1;
    axi.rdata   = 32'h0000_00AA;
    @(negedge clk);
    axi.rdata = 32'h0000_00BB;
    reset     = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    axi.rvalid = 1'b0;
    #1;
    checkOutput("abort rready", axi.rready, 0);
    checkOutput("abort arvalid", axi.arvalid, 0);
    checkOutput("abort ret_valid", dcache_ret_valid, 0);
    checkOutput("abort ret_data", dcache_ret_data, 0);
    @(negedge clk);
    #1;
    checkOutput("abort ret_valid later", dcache_ret_valid, 0);

    readRequest(1'b1, 32'h0000_4040, "after");
    readBody(1'b1, 32'h0000_4040, 128'h55555555_66666666_77777777_88888888, 1, "after");
  endtask

  initial begin
    checkCount      = 0;
    errorCount      = 0;
    reset           = 1'b1;
    dcache_rd_req   = 1'b0;
    dcache_rd_addr  = '0;
    dcache_wr_req   = 1'b0;
    dcache_wr_addr  = '0;
    dcache_wr_data  = '0;
    udcache_rd_req  = 1'b0;
    udcache_rd_addr = '0;
    udcache_wr_req  = 1'b0;
    udcache_wr_addr = '0;
    udcache_wr_data = '0;
    udcache_wr_strb = '0;
    axi.arready     = 1'b0;
    axi.rid         = 4'd1;
    axi.rdata       = '0;
    axi.rresp       = 2'b00;
    axi.rlast       = 1'b0;
    axi.rvalid      = 1'b0;
    axi.awready     = 1'b0;
    axi.wready      = 1'b0;
    axi.bid         = 4'd1;
    axi.bresp       = 2'b00;
    axi.bvalid      = 1'b0;

    applyStimulus();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
